// File: rtl/dmem_if.sv
// dmem_if: MEM-stage load/store bus between the cpu (master) and the data memory (slave).
interface dmem_if;
    logic        hlt;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        err;
    modport master (output hlt, re, we, addr, wdata, input rdata, rvalid, stall, err);
    modport slave (input hlt, re, we, addr, wdata, output rdata, rvalid, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed 16-bit data memory that stalls the pipeline per access.
// Define DMEM_OOR_ERR_EN to flag and suppress accesses with addr >= DEPTH.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q;
    logic [AW-1:0] idx_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [15:0] mem_q [DEPTH];
    logic        acc;
    logic        fire;
    logic        stall;
    logic        oor_q;
`ifdef DMEM_OOR_ERR_EN
    logic oor;
    assign oor = {16'h0, bus.addr} >= 32'(DEPTH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oor_q <= 1'b0;
        else if (acc) oor_q <= oor;
    end
    assign bus.err = (state_q == DONE) && oor_q;
`else
    assign oor_q   = 1'b0;
    assign bus.err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc     = 1'b0;
        fire    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                acc     = (bus.re | bus.we) && !bus.hlt;
                stall   = acc;
                state_d = acc ? BUSY : IDLE;
                cnt_d   = acc ? 4'(LATENCY - 1) : cnt_q;
            end
            BUSY: begin
                stall   = 1'b1;
                fire    = cnt_q == 4'd0;
                state_d = fire ? DONE : BUSY;
                cnt_d   = fire ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc) begin
                op_wr_q <= bus.we;
                idx_q   <= bus.addr[AW-1:0];
                wdata_q <= bus.wdata;
            end
            if (fire && !op_wr_q) rdata_q <= oor_q ? 16'hDEAD : mem_q[idx_q];
        end
    end
    // fire is false while in reset, so an uncommitted write is simply dropped
    always_ff @(posedge clk) begin
        if (fire && op_wr_q && !oor_q) mem_q[idx_q] <= wdata_q;
    end
    assign bus.stall  = rst_n && stall;
    assign bus.rvalid = (state_q == DONE) && !op_wr_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven checks of dmem_responder with a read-data scoreboard.
module tb_dmem_responder;
`ifdef DMEM_OOR_ERR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] sb[$];
    dmem_if bus ();
    dmem_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        re, we, hlt;
        logic [15:0] addr, wdata;
        int          st;
        logic        rv, er;
        logic [15:0] rd;
    } vec_t;
    vec_t vec[11];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && bus.rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra: got rvalid with rdata %h expected no read", bus.rdata);
            end else chk("sb_rdata", bus.rdata, sb.pop_front());
        end
    end
    task automatic run(input logic re, we, hlt, input logic [15:0] a, d,
                       output int st, output logic rv, er, output logic [15:0] rd, output logic quiet);
        @(negedge clk);
        bus.re = re; bus.we = we; bus.hlt = hlt; bus.addr = a; bus.wdata = d;
        #1 st = 0;
        while (bus.stall === 1'b1 && st < 40) begin
            st++;
            @(negedge clk);
            #1;
        end
        rv = bus.rvalid;
        er = bus.err;
        bus.re = 1'b0; bus.we = 1'b0; bus.hlt = 1'b0;
        @(negedge clk);
        #1 rd = bus.rdata;
        quiet = !bus.rvalid && !bus.err && !bus.stall;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end
    initial begin
        int st;
        logic rv, er, q;
        logic [15:0] rd;
        vec[0]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h1234, 3, 1'b0, 1'b0, 16'h0000};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 3, 1'b1, 1'b0, 16'h1234};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 3, 1'b0, 1'b0, 16'h1234};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1'b1, 1'b0, 16'hBEEF};
        vec[4]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, 0, 1'b0, 1'b0, 16'hBEEF};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h4242, 3, 1'b0, 1'b0, 16'hBEEF};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 3, 1'b1, OOR, OOR ? 16'hDEAD : 16'h4242};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 16'h0405, 16'h1111, 3, 1'b0, OOR, OOR ? 16'hDEAD : 16'h4242};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 3, 1'b1, 1'b0, OOR ? 16'h1234 : 16'h1111};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 16'h0007, 16'h5555, 3, 1'b0, 1'b0, OOR ? 16'h1234 : 16'h1111};
        vec[10] = '{1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, 3, 1'b1, 1'b0, 16'h5555};
        bus.re = 1'b0; bus.we = 1'b0; bus.hlt = 1'b0; bus.addr = 16'h0; bus.wdata = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdata", bus.rdata, 16'h0000);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("idle_stall", bus.stall, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (vec[i].rv) sb.push_back(vec[i].rd);
            run(vec[i].re, vec[i].we, vec[i].hlt, vec[i].addr, vec[i].wdata, st, rv, er, rd, q);
            chk($sformatf("v%0d_stall_cycles", i), st, vec[i].st);
            chk($sformatf("v%0d_rvalid", i), rv, vec[i].rv);
            chk($sformatf("v%0d_err", i), er, vec[i].er);
            chk($sformatf("v%0d_rdata", i), rd, vec[i].rd);
            chk($sformatf("v%0d_pulse_end", i), q, 1'b1);
        end
        // hlt raised during the first BUSY cycle must not abort the access
        sb.push_back(OOR ? 16'h1234 : 16'h1111);
        @(negedge clk);
        bus.re = 1'b1; bus.addr = 16'h0005;
        #1 st = 0;
        while (bus.stall === 1'b1 && st < 40) begin
            st++;
            @(negedge clk);
            bus.hlt = 1'b1;
            #1;
        end
        chk("hlt_busy_stall_cycles", st, 3);
        chk("hlt_busy_rvalid", bus.rvalid, 1'b1);
        chk("hlt_busy_rdata", bus.rdata, OOR ? 16'h1234 : 16'h1111);
        bus.re = 1'b0; bus.hlt = 1'b0;
        // reset during BUSY of a write: the write never commits
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 16'h0007; bus.wdata = 16'hAAAA;
        #1 chk("rstmid_accept_stall", bus.stall, 1'b1);
        @(negedge clk);
        #1 chk("rstmid_busy_stall", bus.stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall_drop", bus.stall, 1'b0);
        chk("rstmid_rvalid", bus.rvalid, 1'b0);
        bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rstmid_rdata_cleared", bus.rdata, 16'h0000);
        sb.push_back(16'h5555);
        run(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, st, rv, er, rd, q);
        chk("rstmid_read_cycles", st, 3);
        chk("rstmid_read_rvalid", rv, 1'b1);
        chk("rstmid_read_rdata", rd, 16'h5555);
        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
